// File: rtl/rpmb_pkg.sv
`default_nettype none
// ============================================================================
// rpmb_pkg : shared encodings for the MSX-to-host bus bridge.
// Revision : 1.0
// ============================================================================
package rpmb_pkg;

    localparam logic [1:0] REG_CS1  = 2'd0;
    localparam logic [1:0] REG_CS2  = 2'd1;
    localparam logic [1:0] REG_CS12 = 2'd2;
    localparam logic [1:0] REG_IO   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Wide enough for any DATA_W in use; sliced down at the point of use.
    localparam logic [63:0] TIMEOUT_RDATA = '1;

endpackage
`default_nettype wire

// File: rtl/rpmb_sync.sv
`default_nettype none
// ============================================================================
// rpmb_sync : STAGES-deep single-bit synchroniser with selectable reset value.
// Revision  : 1.0
// ============================================================================
module rpmb_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rpmb_bus_bridge.sv
`default_nettype none
// ============================================================================
// rpmb_bus_bridge : MSX cartridge bus to host req/ack bridge with WAIT control.
// Optional I/O-cycle forwarding enabled by defining RPMB_IO_EN.
// Revision        : 1.0
// ============================================================================
module rpmb_bus_bridge
    import rpmb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] msx_a,
    input  logic [DATA_W-1:0] msx_d_in,
    output logic [DATA_W-1:0] msx_d_out,
    output logic              msx_d_oe,
    input  logic              msx_rd_n,
    input  logic              msx_wr_n,
    input  logic              msx_iorq_n,
    input  logic              msx_mreq_n,
    input  logic              msx_cs1_n,
    input  logic              msx_cs2_n,
    input  logic              msx_cs12_n,
    output logic              msx_wait_n,
    output logic              host_req,
    output logic              host_rw,
    output logic [1:0]        host_region,
    output logic [ADDR_W-1:0] host_addr,
    output logic [DATA_W-1:0] host_wdata,
    input  logic [DATA_W-1:0] host_rdata,
    input  logic              host_ack,
    output logic              timeout_flag
);

    localparam int          c_ix_rd    = 0;
    localparam int          c_ix_wr    = 1;
    localparam int          c_ix_cs1   = 2;
    localparam int          c_ix_cs2   = 3;
    localparam int          c_ix_cs12  = 4;
    localparam logic [15:0] c_cnt_last = 16'(TIMEOUT_CYC - 1);
`ifdef RPMB_IO_EN
    localparam int          c_ix_iorq  = 5;
    localparam int          c_n_ctrl   = 6;
`else
    localparam int          c_n_ctrl   = 5;
`endif

    logic [c_n_ctrl-1:0] w_ctrl_raw;
    logic [c_n_ctrl-1:0] w_ctrl_sync;
    logic                unused_inputs;

`ifdef RPMB_IO_EN
    assign w_ctrl_raw    = {msx_iorq_n, msx_cs12_n, msx_cs2_n, msx_cs1_n, msx_wr_n, msx_rd_n};
    assign unused_inputs = msx_mreq_n;
`else
    assign w_ctrl_raw    = {msx_cs12_n, msx_cs2_n, msx_cs1_n, msx_wr_n, msx_rd_n};
    assign unused_inputs = msx_mreq_n & msx_iorq_n;
`endif

    for (genvar gi = 0; gi < c_n_ctrl; gi++) begin : g_sync
        rpmb_sync #(
            .STAGES    (SYNC_STAGES),
            .RESET_VAL (1'b1)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (w_ctrl_raw[gi]),
            .q     (w_ctrl_sync[gi])
        );
    end

    state_t            r_state, w_state_next;
    logic [15:0]       r_cnt, w_cnt_next;
    logic              r_pending, w_pending_next;
    logic              r_strobe_prev;
    logic              r_req, w_req_next;
    logic              r_rw, w_rw_next;
    logic              r_wait_n, w_wait_n_next;
    logic              r_oe, w_oe_next;
    logic              r_to, w_to_next;
    logic [1:0]        r_region, w_region_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [DATA_W-1:0] r_wdata, w_wdata_next;
    logic [DATA_W-1:0] r_dout, w_dout_next;

    logic              w_idle_strobe;
    logic              w_fall;
    logic              w_sel;
    logic              w_start_cand;
    logic [1:0]        w_region;
    logic [ADDR_W-1:0] w_addr;

    // High while neither read nor write strobe is active.
    assign w_idle_strobe = w_ctrl_sync[c_ix_rd] & w_ctrl_sync[c_ix_wr];
    assign w_fall        = r_strobe_prev & ~w_idle_strobe;
    // A start seen while the host still holds ack is remembered until ack drops.
    assign w_start_cand  = (w_fall | r_pending) & ~w_idle_strobe & w_sel;

    always_comb begin
        w_region = REG_CS1;
        w_addr   = msx_a;
        w_sel    = 1'b1;
        if (!w_ctrl_sync[c_ix_cs1]) begin
            w_region = REG_CS1;
        end else if (!w_ctrl_sync[c_ix_cs2]) begin
            w_region = REG_CS2;
        end else if (!w_ctrl_sync[c_ix_cs12]) begin
            w_region = REG_CS12;
`ifdef RPMB_IO_EN
        end else if (!w_ctrl_sync[c_ix_iorq]) begin
            w_region = REG_IO;
            w_addr   = ADDR_W'(msx_a[7:0]);
`endif
        end else begin
            w_sel    = 1'b0;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_pending_next = 1'b0;
        w_req_next     = r_req;
        w_rw_next      = r_rw;
        w_wait_n_next  = r_wait_n;
        w_oe_next      = r_oe;
        w_to_next      = 1'b0;
        w_region_next  = r_region;
        w_addr_next    = r_addr;
        w_wdata_next   = r_wdata;
        w_dout_next    = r_dout;
        case (r_state)
            IDLE: begin
                w_pending_next = w_start_cand & host_ack;
                if (w_start_cand && !host_ack) begin
                    w_addr_next   = w_addr;
                    w_region_next = w_region;
                    w_rw_next     = ~w_ctrl_sync[c_ix_wr];
                    if (!w_ctrl_sync[c_ix_wr]) begin
                        w_wdata_next = msx_d_in;
                    end
                    w_req_next    = 1'b1;
                    w_wait_n_next = 1'b0;
                    w_cnt_next    = '0;
                    w_state_next  = REQ;
                end
            end
            REQ: begin
                w_cnt_next = r_cnt + 16'd1;
                if (host_ack || r_cnt == c_cnt_last) begin
                    w_req_next    = 1'b0;
                    w_wait_n_next = 1'b1;
                    if (!r_rw) begin
                        w_dout_next = host_ack ? host_rdata : TIMEOUT_RDATA[DATA_W-1:0];
                        w_oe_next   = 1'b1;
                    end
                    w_to_next     = ~host_ack;
                    w_state_next  = HOLD;
                end
            end
            HOLD: begin
                if (w_idle_strobe) begin
                    w_oe_next    = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_pending     <= 1'b0;
            r_strobe_prev <= 1'b1;
            r_req         <= 1'b0;
            r_rw          <= 1'b0;
            r_wait_n      <= 1'b1;
            r_oe          <= 1'b0;
            r_to          <= 1'b0;
            r_region      <= REG_CS1;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_dout        <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_pending     <= w_pending_next;
            r_strobe_prev <= w_idle_strobe;
            r_req         <= w_req_next;
            r_rw          <= w_rw_next;
            r_wait_n      <= w_wait_n_next;
            r_oe          <= w_oe_next;
            r_to          <= w_to_next;
            r_region      <= w_region_next;
            r_addr        <= w_addr_next;
            r_wdata       <= w_wdata_next;
            r_dout        <= w_dout_next;
        end
    end

    assign msx_d_out    = r_dout;
    assign msx_d_oe     = r_oe;
    assign msx_wait_n   = r_wait_n;
    assign host_req     = r_req;
    assign host_rw      = r_rw;
    assign host_region  = r_region;
    assign host_addr    = r_addr;
    assign host_wdata   = r_wdata;
    assign timeout_flag = r_to;

endmodule
`default_nettype wire

// File: tb/tb_rpmb_bus_bridge.sv
`default_nettype none
// ============================================================================
// tb_rpmb_bus_bridge : self-checking bench for rpmb_bus_bridge.
// Revision           : 1.0
// ============================================================================
module tb_rpmb_bus_bridge;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int SS = 2;
    localparam int TO = 16;
`ifdef RPMB_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic [AW-1:0] msx_a      = '0;
    logic [DW-1:0] msx_d_in   = '0;
    logic [DW-1:0] msx_d_out;
    logic          msx_d_oe;
    logic          msx_rd_n   = 1'b1;
    logic          msx_wr_n   = 1'b1;
    logic          msx_iorq_n = 1'b1;
    logic          msx_mreq_n = 1'b1;
    logic          msx_cs1_n  = 1'b1;
    logic          msx_cs2_n  = 1'b1;
    logic          msx_cs12_n = 1'b1;
    logic          msx_wait_n;
    logic          host_req;
    logic          host_rw;
    logic [1:0]    host_region;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata = '0;
    logic          host_ack   = 1'b0;
    logic          timeout_flag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rpmb_bus_bridge #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .SYNC_STAGES (SS),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .msx_a        (msx_a),
        .msx_d_in     (msx_d_in),
        .msx_d_out    (msx_d_out),
        .msx_d_oe     (msx_d_oe),
        .msx_rd_n     (msx_rd_n),
        .msx_wr_n     (msx_wr_n),
        .msx_iorq_n   (msx_iorq_n),
        .msx_mreq_n   (msx_mreq_n),
        .msx_cs1_n    (msx_cs1_n),
        .msx_cs2_n    (msx_cs2_n),
        .msx_cs12_n   (msx_cs12_n),
        .msx_wait_n   (msx_wait_n),
        .host_req     (host_req),
        .host_rw      (host_rw),
        .host_region  (host_region),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .host_ack     (host_ack),
        .timeout_flag (timeout_flag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Region the bridge should report, or -1 when the cycle must be ignored.
    function automatic int model_region(input logic cs1_n, input logic cs2_n,
                                        input logic cs12_n, input logic iorq_n);
        if (!cs1_n)  return 0;
        if (!cs2_n)  return 1;
        if (!cs12_n) return 2;
        if (IO_EN && !iorq_n) return 3;
        return -1;
    endfunction

    // One full MSX bus cycle; sel_n = {iorq_n, cs12_n, cs2_n, cs1_n}.
    // The host raises ack ack_dly cycles after seeing host_req.
    task automatic run_cycle(input string name, input bit wr, input logic [3:0] sel_n,
                             input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input int ack_dly, input logic [DW-1:0] rd);
        int            reg_exp;
        logic [AW-1:0] a_exp;
        logic [DW-1:0] d_exp;
        logic [1:0]    reg2;
        int            t_exp;
        bit            to_exp;
        int            t;
        reg_exp = model_region(sel_n[0], sel_n[1], sel_n[2], sel_n[3]);
        reg2    = reg_exp[1:0];
        a_exp   = (reg_exp == 3) ? {8'h00, a[7:0]} : a;
        to_exp  = (ack_dly >= TO);
        t_exp   = to_exp ? TO : ack_dly + 1;
        d_exp   = to_exp ? 8'hFF : rd;

        msx_a = a;
        msx_d_in = wd;
        {msx_iorq_n, msx_cs12_n, msx_cs2_n, msx_cs1_n} = sel_n;
        msx_mreq_n = ~sel_n[3];
        if (wr) msx_wr_n = 1'b0;
        else    msx_rd_n = 1'b0;

        for (int i = 0; i < SS; i++) begin
            tick();
            n_tests++;
            if (host_req !== 1'b0 || msx_wait_n !== 1'b1) begin
                n_fail++;
                $display("FAIL %s early_req: req=%0b wait_n=%0b required req=0 wait_n=1",
                         name, host_req, msx_wait_n);
            end
        end
        tick();

        if (reg_exp < 0) begin
            n_tests++;
            if (host_req !== 1'b0 || msx_wait_n !== 1'b1) begin
                n_fail++;
                $display("FAIL %s ignored: req=%0b wait_n=%0b required req=0 wait_n=1",
                         name, host_req, msx_wait_n);
            end
            repeat (4) tick();
            n_tests++;
            if (host_req !== 1'b0 || msx_wait_n !== 1'b1) begin
                n_fail++;
                $display("FAIL %s ignored_late: req=%0b wait_n=%0b required req=0 wait_n=1",
                         name, host_req, msx_wait_n);
            end
            msx_rd_n = 1'b1; msx_wr_n = 1'b1;
            {msx_iorq_n, msx_cs12_n, msx_cs2_n, msx_cs1_n} = 4'hF;
            msx_mreq_n = 1'b1;
        end else begin
            n_tests++;
            if (host_req !== 1'b1 || msx_wait_n !== 1'b0) begin
                n_fail++;
                $display("FAIL %s req_start: req=%0b wait_n=%0b required req=1 wait_n=0",
                         name, host_req, msx_wait_n);
            end
            n_tests++;
            if (host_rw !== wr || host_region !== reg2 || host_addr !== a_exp ||
                (wr && host_wdata !== wd)) begin
                n_fail++;
                $display("FAIL %s latch: rw=%0b region=%0d addr=%h wdata=%h required rw=%0b region=%0d addr=%h wdata=%h",
                         name, host_rw, host_region, host_addr, host_wdata, wr, reg2, a_exp, wd);
            end
            t = 0;
            while (host_req === 1'b1 && t <= TO + 4) begin
                if (t == ack_dly) begin
                    host_ack = 1'b1;
                    host_rdata = rd;
                end
                tick();
                t++;
                if (host_req === 1'b1) begin
                    n_tests++;
                    if (msx_wait_n !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s wait_held: wait_n=%0b required 0 at t=%0d", name, msx_wait_n, t);
                    end
                end
            end
            n_tests++;
            if (t != t_exp) begin
                n_fail++;
                $display("FAIL %s complete_time: cycles=%0d required %0d", name, t, t_exp);
            end
            n_tests++;
            if (msx_wait_n !== 1'b1 || timeout_flag !== to_exp || msx_d_oe !== !wr ||
                (!wr && msx_d_out !== d_exp)) begin
                n_fail++;
                $display("FAIL %s complete: wait_n=%0b tflag=%0b oe=%0b dout=%h required wait_n=1 tflag=%0b oe=%0b dout=%h",
                         name, msx_wait_n, timeout_flag, msx_d_oe, msx_d_out, to_exp, !wr, d_exp);
            end
            host_ack = 1'b0;
            msx_rd_n = 1'b1; msx_wr_n = 1'b1;
            {msx_iorq_n, msx_cs12_n, msx_cs2_n, msx_cs1_n} = 4'hF;
            msx_mreq_n = 1'b1;
            for (int i = 0; i < SS; i++) begin
                tick();
                if (i == 0) begin
                    n_tests++;
                    if (timeout_flag !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s flag_pulse: tflag=%0b required 0", name, timeout_flag);
                    end
                end
            end
            n_tests++;
            if (msx_d_oe !== !wr) begin
                n_fail++;
                $display("FAIL %s oe_hold: oe=%0b required %0b", name, msx_d_oe, !wr);
            end
            tick();
            n_tests++;
            if (msx_d_oe !== 1'b0) begin
                n_fail++;
                $display("FAIL %s oe_drop: oe=%0b required 0", name, msx_d_oe);
            end
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (msx_wait_n !== 1'b1 || msx_d_oe !== 1'b0 || host_req !== 1'b0 ||
            host_rw !== 1'b0 || timeout_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: wait_n=%0b oe=%0b req=%0b rw=%0b tflag=%0b required 1 0 0 0 0",
                     msx_wait_n, msx_d_oe, host_req, host_rw, timeout_flag);
        end
        n_tests++;
        if (msx_d_out !== '0 || host_region !== 2'd0 || host_addr !== '0 || host_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: dout=%h region=%0d addr=%h wdata=%h required all zero",
                     msx_d_out, host_region, host_addr, host_wdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cs1_read();
        run_cycle("cs1_read", 1'b0, 4'b1110, 16'h4000, 8'h00, 10, 8'h5A);
    endtask

    task automatic test_cs2_write();
        run_cycle("cs2_write", 1'b1, 4'b1101, 16'h8123, 8'hC3, 3, 8'h00);
    endtask

    task automatic test_cs12_read();
        run_cycle("cs12_read", 1'b0, 4'b1011, 16'hC0DE, 8'h00, 0, 8'h81);
    endtask

    task automatic test_timeout();
        run_cycle("timeout_read", 1'b0, 4'b1110, 16'h5555, 8'h00, TO + 3, 8'h12);
        run_cycle("timeout_write", 1'b1, 4'b1101, 16'h9001, 8'h77, TO + 3, 8'h00);
    endtask

    task automatic test_ack_timeout_tie();
        run_cycle("ack_tie", 1'b0, 4'b1110, 16'h6789, 8'h00, TO - 1, 8'h66);
    endtask

    task automatic test_io();
        run_cycle("io_write", 1'b1, 4'b0111, 16'hAB98, 8'h4E, 2, 8'h00);
    endtask

    task automatic test_no_sel();
        run_cycle("no_sel", 1'b0, 4'b1111, 16'h1234, 8'h00, 1, 8'h99);
    endtask

    task automatic test_ack_held();
        host_ack = 1'b1;
        host_rdata = 8'h3C;
        msx_a = 16'h4100;
        msx_cs1_n = 1'b0;
        msx_rd_n = 1'b0;
        repeat (SS + 3) tick();
        n_tests++;
        if (host_req !== 1'b0 || msx_wait_n !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_held_wait: req=%0b wait_n=%0b required req=0 wait_n=1", host_req, msx_wait_n);
        end
        host_ack = 1'b0;
        tick();
        n_tests++;
        if (host_req !== 1'b1 || msx_wait_n !== 1'b0 || host_addr !== 16'h4100 || host_region !== 2'd0) begin
            n_fail++;
            $display("FAIL ack_held_start: req=%0b wait_n=%0b addr=%h region=%0d required 1 0 4100 0",
                     host_req, msx_wait_n, host_addr, host_region);
        end
        host_ack = 1'b1;
        tick();
        n_tests++;
        if (msx_wait_n !== 1'b1 || msx_d_oe !== 1'b1 || msx_d_out !== 8'h3C) begin
            n_fail++;
            $display("FAIL ack_held_done: wait_n=%0b oe=%0b dout=%h required 1 1 3c", msx_wait_n, msx_d_oe, msx_d_out);
        end
        host_ack = 1'b0;
        msx_rd_n = 1'b1;
        msx_cs1_n = 1'b1;
        repeat (SS + 1) tick();
        n_tests++;
        if (msx_d_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_held_oe: oe=%0b required 0", msx_d_oe);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        msx_a = 16'h6000;
        msx_cs1_n = 1'b0;
        msx_rd_n = 1'b0;
        repeat (SS + 1) tick();
        n_tests++;
        if (host_req !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: req=%0b required 1", host_req);
        end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if (msx_wait_n !== 1'b1 || host_req !== 1'b0 || msx_d_oe !== 1'b0 || timeout_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: wait_n=%0b req=%0b oe=%0b tflag=%0b required 1 0 0 0",
                     msx_wait_n, host_req, msx_d_oe, timeout_flag);
        end
        msx_rd_n = 1'b1;
        msx_cs1_n = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        run_cycle("post_reset_read", 1'b0, 4'b1110, 16'h4321, 8'h00, 5, 8'hA7);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 24; k++) begin
            logic [3:0]    s;
            logic [AW-1:0] a;
            logic [DW-1:0] wd;
            logic [DW-1:0] rd;
            bit            w;
            int            d;
            s  = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            wd = 8'($urandom);
            rd = 8'($urandom);
            w  = 1'($urandom_range(0, 1));
            d  = $urandom_range(0, TO + 2);
            run_cycle($sformatf("rand%0d", k), w, s, a, wd, d, rd);
        end
    endtask

    initial begin
        test_reset();
        test_cs1_read();
        test_cs2_write();
        test_cs12_read();
        test_timeout();
        test_ack_timeout_tie();
        test_io();
        test_no_sel();
        test_ack_held();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/rpmb_bus_bridge.md
Name: rpmb_bus_bridge

Overview:
Parametrised next-generation MSX-cartridge-to-host bridge.
- Samples MSX bus strobes into the single host clock domain.
- Decodes the cycle window: CS1, CS2, CS12 and, optionally, I/O.
- Forwards each cycle to the host over a req/ack handshake, holding MSX WAIT low until the host answers or a timeout expires.
- Sits between the MSX cartridge connector pins and the host (Raspberry Pi) GPIO interface.

Parameters:
ADDR_W, 16, MSX address width forwarded to host
DATA_W, 8, MSX data width
SYNC_STAGES, 2, synchroniser depth for MSX control inputs (min 2)
TIMEOUT_CYC, 255, clk cycles in REQ before forced completion (1..65535)

Ports:
clk  in  1  bridge clock, all logic on posedge
reset  in  1  synchronous, active-high
msx_a  in  ADDR_W  MSX address
msx_d_in  in  DATA_W  MSX data bus, input side
msx_d_out  out  DATA_W  read data to MSX
msx_d_oe  out  1  MSX data driver enable
msx_rd_n, msx_wr_n, msx_iorq_n, msx_mreq_n  in  1 each  MSX strobes, active-low
msx_cs1_n, msx_cs2_n, msx_cs12_n  in  1 each  MSX chip selects, active-low
msx_wait_n  out  1  MSX WAIT, active-low
host_req  out  1  cycle request to host
host_rw  out  1  1 = write, 0 = read
host_region  out  2  0 = CS1, 1 = CS2, 2 = CS12-only, 3 = IO
host_addr  out  ADDR_W  latched address
host_wdata  out  DATA_W  latched write data
host_rdata  in  DATA_W  host read data, valid with host_ack
host_ack  in  1  host completion
timeout_flag  out  1  one-cycle pulse on timeout

Behaviour:
Reset state: msx_wait_n=1, msx_d_oe=0, msx_d_out=0, host_req=0, host_rw=0, host_region=0, host_addr=0, host_wdata=0, timeout_flag=0; FSM=IDLE.

Synchronisers:
- All MSX control inputs pass through SYNC_STAGES flops.
- msx_a and msx_d_in are sampled raw, only in the cycle a strobe edge is detected. They are stable by then.

sel:
- sel = any synced cs*_n low.
- With RPMB_IO_EN defined, sel is also true when iorq_n is low.

Region priority: cs1 > cs2 > cs12 > io.

FSM:
- IDLE
  - Start condition: synced (rd_n & wr_n) goes 1→0, sel=1, host_ack=0.
  - On start, in one cycle: latch address, region, rw=!wr_n and wdata (writes); assert host_req=1 and msx_wait_n=0; clear timeout counter; go REQ.
  - If host_ack is still high, stay in IDLE and take the start once ack falls, provided the strobe is still low.
- REQ
  - Counter increments each cycle.
  - On host_ack=1:
    - host_req←0, msx_wait_n←1.
    - Read: msx_d_out←host_rdata, msx_d_oe←1.
    - Go HOLD.
  - On counter==TIMEOUT_CYC-1 without ack:
    - Same as ack, but read data is all-ones (0xFF).
    - timeout_flag pulses one cycle.
    - Go HOLD.
  - If ack and timeout occur in the same cycle, ack wins and no flag is raised.
- HOLD
  - Wait until synced rd_n=1 and wr_n=1.
  - Then msx_d_oe←0 and go IDLE.
  - msx_d_oe therefore trails rd_n rise by SYNC_STAGES+1 clk cycles; this is accepted.

Latency:
- Strobe fall to host_req: SYNC_STAGES+1 cycles.
- host_ack to WAIT release: 1 cycle.

Other rules:
- A strobe edge while sel=0 is ignored.
- host_req is level-held until ack. The host must drop ack before the next request is issued.
- Reset mid-cycle: WAIT is released and oe is dropped on the next edge. The host sees req fall without ack.

Optional Feature:
Macro: RPMB_IO_EN.
- Defined: MSX I/O cycles (iorq_n low with rd/wr; cs lines ignored) are forwarded with region=3. host_addr holds msx_a[7:0], zero-extended.
- Undefined: iorq_n is not synchronised, region 3 is never produced, and I/O cycles never assert WAIT.

Decomposition:
- Package rpmb_pkg holds:
  - region encoding constants REG_CS1, REG_CS2, REG_CS12, REG_IO
  - the FSM state enum (IDLE, REQ, HOLD)
  - the all-ones timeout read value
- One sub-module: rpmb_sync, a parametrised SYNC_STAGES-deep single-bit synchroniser instantiated per control input.

Test Plan:
- Memory read in CS1 at 0x4000, host acks after 10 cycles with 0x5A → WAIT low from cycle 3 until 1 cycle after ack; msx_d_out=0x5A with oe=1; region=0; oe drops after rd_n rises.
- Write in CS2 at 0x8123, data 0xC3 → host_rw=1, host_addr=0x8123, host_wdata=0xC3, region=1; oe stays 0.
- Read with no ack, TIMEOUT_CYC=16 → timeout_flag pulses once at cycle 16 of REQ; WAIT released; msx_d_out=0xFF.
- Ack and timeout asserted in the same cycle → host data returned, no timeout_flag.
- With RPMB_IO_EN, IO write to port 0x98 → region=3, host_addr=0x0098. Without the macro → no host_req, WAIT stays high.
- Reset asserted while in REQ → next cycle msx_wait_n=1, host_req=0, oe=0, FSM IDLE; the following read completes normally.
